// File: rtl/dmem_arb.sv
// dmem_arb: round-robin two-master arbiter and byte/half/word access formatter for the dmem RAM
module dmem_arb #(
    parameter int ADDR_WIDTH = 12
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    m0_req,
    input  logic                    m0_we,
    input  logic [ADDR_WIDTH+1:0]   m0_addr,
    input  logic [1:0]              m0_size,
    input  logic                    m0_unsigned,
    input  logic [31:0]             m0_wdata,
    output logic                    m0_gnt,
    output logic                    m0_done,
    output logic [31:0]             m0_rdata,
    output logic                    m0_err,
    input  logic                    m1_req,
    input  logic                    m1_we,
    input  logic [ADDR_WIDTH+1:0]   m1_addr,
    input  logic [1:0]              m1_size,
    input  logic                    m1_unsigned,
    input  logic [31:0]             m1_wdata,
    output logic                    m1_gnt,
    output logic                    m1_done,
    output logic [31:0]             m1_rdata,
    output logic                    m1_err,
    output logic                    mem_we,
    output logic [3:0]              mem_byte_en,
    output logic [ADDR_WIDTH-1:0]   mem_addr_w,
    output logic [31:0]             mem_wdata,
    output logic                    mem_ren,
    output logic [ADDR_WIDTH-1:0]   mem_addr_r,
    input  logic [31:0]             mem_rdata
);
    logic last_q, last_d;
    logic rv_q, rv_d, rid_q, rid_d, rwe_q, rwe_d, runs_q, runs_d, rerr_q, rerr_d;
    logic [1:0] rsize_q, rsize_d, roff_q, roff_d;
    logic g0, g1, gnt, sel_we, sel_uns, mis, act;
    logic [ADDR_WIDTH+1:0] sel_addr;
    logic [1:0] sel_size, off;
    logic [31:0] sel_wdata, sh, rd;
    always_comb begin
        g0 = !rst && m0_req && (!m1_req || last_q);
        g1 = !rst && m1_req && !g0;
        gnt = g0 || g1;
        sel_we = g1 ? m1_we : m0_we;
        sel_uns = g1 ? m1_unsigned : m0_unsigned;
        sel_addr = g1 ? m1_addr : m0_addr;
        sel_size = g1 ? m1_size : m0_size;
        sel_wdata = g1 ? m1_wdata : m0_wdata;
        off = sel_addr[1:0];
        mis = (sel_size == 2'b01 && off[0]) || (sel_size[1] && off != 2'b00);
        act = gnt && !mis;
        mem_we = act && sel_we;
        mem_ren = act && !sel_we;
        mem_addr_w = act ? sel_addr[ADDR_WIDTH+1:2] : '0;
        mem_addr_r = mem_addr_w;
        mem_byte_en = !mem_we ? 4'b0000 :
                      sel_size == 2'b00 ? 4'b0001 << off :
                      sel_size == 2'b01 ? 4'b0011 << off : 4'b1111;
        mem_wdata = !mem_we ? 32'h0 :
                    sel_size == 2'b00 ? {4{sel_wdata[7:0]}} :
                    sel_size == 2'b01 ? {2{sel_wdata[15:0]}} : sel_wdata;
        last_d = gnt ? g1 : last_q;
        rv_d = gnt;
        rid_d = g1;
        rwe_d = gnt && sel_we;
        runs_d = gnt && sel_uns;
        rsize_d = gnt ? sel_size : 2'b00;
        roff_d = gnt ? off : 2'b00;
        rerr_d = gnt && mis;
        sh = mem_rdata >> {roff_q, 3'b000};
        rd = (!rv_q || rwe_q || rerr_q) ? 32'h0 :
             rsize_q == 2'b00 ? {{24{!runs_q && sh[7]}}, sh[7:0]} :
             rsize_q == 2'b01 ? {{16{!runs_q && sh[15]}}, sh[15:0]} : sh;
        m0_gnt = g0;
        m1_gnt = g1;
        m0_done = rv_q && !rid_q;
        m1_done = rv_q && rid_q;
        m0_err = m0_done && rerr_q;
        m1_err = m1_done && rerr_q;
        m0_rdata = m0_done ? rd : 32'h0;
        m1_rdata = m1_done ? rd : 32'h0;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q <= 1'b1;
            rv_q <= 1'b0;
            rid_q <= 1'b0;
            rwe_q <= 1'b0;
            runs_q <= 1'b0;
            rsize_q <= 2'b00;
            roff_q <= 2'b00;
            rerr_q <= 1'b0;
        end else begin
            last_q <= last_d;
            rv_q <= rv_d;
            rid_q <= rid_d;
            rwe_q <= rwe_d;
            runs_q <= runs_d;
            rsize_q <= rsize_d;
            roff_q <= roff_d;
            rerr_q <= rerr_d;
        end
    end
endmodule

// File: tb/tb_dmem_arb.sv
// tb_dmem_arb: directed bench with a byte-level reference model of arbitration, formatting and memory
module tb_dmem_arb;
    localparam int AW = 12;
    logic clk = 0, rst = 1;
    logic m0_req = 0, m0_we = 0, m0_unsigned = 0;
    logic m1_req = 0, m1_we = 0, m1_unsigned = 0;
    logic [AW+1:0] m0_addr = '0, m1_addr = '0;
    logic [1:0] m0_size = '0, m1_size = '0;
    logic [31:0] m0_wdata = '0, m1_wdata = '0;
    logic m0_gnt, m0_done, m0_err, m1_gnt, m1_done, m1_err;
    logic [31:0] m0_rdata, m1_rdata;
    logic mem_we, mem_ren;
    logic [3:0] mem_byte_en;
    logic [AW-1:0] mem_addr_w, mem_addr_r;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = '0;
    logic [31:0] dm [0:(1<<AW)-1];
    logic [7:0] mb [0:(1<<(AW+2))-1];
    int checks = 0, failures = 0;
    logic mlast = 1, pv = 0, pm = 0, perr = 0;
    logic [31:0] prd = '0;

    dmem_arb #(.ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_size(m0_size),
        .m0_unsigned(m0_unsigned), .m0_wdata(m0_wdata), .m0_gnt(m0_gnt),
        .m0_done(m0_done), .m0_rdata(m0_rdata), .m0_err(m0_err),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_size(m1_size),
        .m1_unsigned(m1_unsigned), .m1_wdata(m1_wdata), .m1_gnt(m1_gnt),
        .m1_done(m1_done), .m1_rdata(m1_rdata), .m1_err(m1_err),
        .mem_we(mem_we), .mem_byte_en(mem_byte_en), .mem_addr_w(mem_addr_w),
        .mem_wdata(mem_wdata), .mem_ren(mem_ren), .mem_addr_r(mem_addr_r),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        for (int i = 0; i < 4; i++)
            if (mem_we && mem_byte_en[i]) dm[mem_addr_w][8*i+:8] <= mem_wdata[8*i+:8];
        if (mem_ren) mem_rdata <= dm[mem_addr_r];
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        logic e0, e1, we_s, uns_s;
        logic [AW+1:0] a;
        logic [1:0] sz;
        logic [31:0] wd, ewd, v;
        logic [3:0] ebe;
        int n, o;
        logic mis;
        if (rst) begin
            chk("rst_m0_gnt", 32'(m0_gnt), 0);
            chk("rst_m1_gnt", 32'(m1_gnt), 0);
            chk("rst_m0_done", 32'(m0_done), 0);
            chk("rst_m1_done", 32'(m1_done), 0);
            chk("rst_errs", 32'({m0_err, m1_err}), 0);
            chk("rst_rdata", m0_rdata | m1_rdata, 0);
            chk("rst_mem_ctl", 32'({mem_we, mem_ren, mem_byte_en}), 0);
            chk("rst_mem_addr", 32'({mem_addr_w, mem_addr_r}), 0);
            chk("rst_mem_wdata", mem_wdata, 0);
            pv = 0;
            mlast = 1;
        end else begin
            e0 = m0_req && (!m1_req || mlast);
            e1 = m1_req && !e0;
            we_s = e1 ? m1_we : m0_we;
            uns_s = e1 ? m1_unsigned : m0_unsigned;
            a = e1 ? m1_addr : m0_addr;
            sz = e1 ? m1_size : m0_size;
            wd = e1 ? m1_wdata : m0_wdata;
            n = sz == 2'b00 ? 1 : sz == 2'b01 ? 2 : 4;
            o = int'(a[1:0]);
            mis = (o % n) != 0;
            chk("m0_gnt", 32'(m0_gnt), 32'(e0));
            chk("m1_gnt", 32'(m1_gnt), 32'(e1));
            chk("m0_done", 32'(m0_done), 32'(pv && !pm));
            chk("m1_done", 32'(m1_done), 32'(pv && pm));
            chk("m0_err", 32'(m0_err), 32'(pv && !pm && perr));
            chk("m1_err", 32'(m1_err), 32'(pv && pm && perr));
            chk("m0_rdata", m0_rdata, (pv && !pm) ? prd : 0);
            chk("m1_rdata", m1_rdata, (pv && pm) ? prd : 0);
            v = 0;
            if (!(e0 || e1)) begin
                chk("idle_mem_ctl", 32'({mem_we, mem_ren, mem_byte_en}), 0);
                chk("idle_mem_addr", 32'({mem_addr_w, mem_addr_r}), 0);
                chk("idle_mem_wdata", mem_wdata, 0);
            end else begin
                chk("mem_we", 32'(mem_we), 32'(!mis && we_s));
                chk("mem_ren", 32'(mem_ren), 32'(!mis && !we_s));
                if (!mis) begin
                    chk("mem_addr_w", 32'(mem_addr_w), 32'(a >> 2));
                    chk("mem_addr_r", 32'(mem_addr_r), 32'(a >> 2));
                    if (we_s) begin
                        ebe = 0;
                        ewd = 0;
                        for (int i = 0; i < 4; i++) begin
                            if (i >= o && i < o + n) ebe[i] = 1;
                            ewd[8*i+:8] = wd[8*(i%n)+:8];
                        end
                        chk("mem_byte_en", 32'(mem_byte_en), 32'(ebe));
                        chk("mem_wdata", mem_wdata, ewd);
                        for (int k = 0; k < n; k++) mb[int'(a)+k] = wd[8*k+:8];
                    end else begin
                        chk("load_byte_en", 32'(mem_byte_en), 0);
                        for (int k = 0; k < n; k++) v[8*k+:8] = mb[int'(a)+k];
                        if (n < 4 && !uns_s && v[8*n-1]) v = v | (32'hFFFFFFFF << (8*n));
                    end
                end
            end
            pv = e0 || e1;
            pm = e1;
            perr = mis;
            prd = (pv && !we_s && !mis) ? v : 0;
            if (pv) mlast = e1;
        end
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic set0(input logic r, input logic w, input logic [AW+1:0] ad, input logic [1:0] s, input logic u, input logic [31:0] d);
        m0_req = r; m0_we = w; m0_addr = ad; m0_size = s; m0_unsigned = u; m0_wdata = d;
    endtask

    task automatic set1(input logic r, input logic w, input logic [AW+1:0] ad, input logic [1:0] s, input logic u, input logic [31:0] d);
        m1_req = r; m1_we = w; m1_addr = ad; m1_size = s; m1_unsigned = u; m1_wdata = d;
    endtask

    task automatic op0(input int k);
        set0(1, !k[0], 14'(32'h20 + (k >> 1)), 2'b00, k[1], 32'(32'h80 + k * 7));
    endtask

    task automatic op1(input int k);
        set1(1, k[0], 14'(32'h20 + 2 * (k % 4)), 2'b01, 1'b0, 32'(32'h8000 + k * 32'h123));
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        int k0, k1;
        logic g0, g1;
        for (int i = 0; i < (1 << AW); i++) dm[i] = 0;
        for (int i = 0; i < (1 << (AW + 2)); i++) mb[i] = 0;
        step; step;
        rst = 0;
        // word store then signed word load at 0x010
        step; set0(1, 1, 14'h010, 2'b10, 0, 32'hDEADBEEF);
        @(negedge clk);
        chk("t1_gnt", 32'(m0_gnt), 1);
        chk("t1_be", 32'(mem_byte_en), 32'hF);
        chk("t1_addr_w", 32'(mem_addr_w), 4);
        step; set0(1, 0, 14'h010, 2'b10, 0, 0);
        @(negedge clk);
        chk("t1_store_done", 32'(m0_done), 1);
        step; m0_req = 0;
        @(negedge clk);
        chk("t1_load_done", 32'(m0_done), 1);
        chk("t1_load_rdata", m0_rdata, 32'hDEADBEEF);
        // m1 byte store 0x80 at 0x013, signed/unsigned reads
        step; set1(1, 1, 14'h013, 2'b00, 0, 32'h80);
        @(negedge clk);
        chk("t2_be", 32'(mem_byte_en), 32'h8);
        chk("t2_wdata", mem_wdata, 32'h80808080);
        step; set1(1, 0, 14'h013, 2'b00, 0, 0);
        step; set1(1, 0, 14'h013, 2'b00, 1, 0);
        @(negedge clk);
        chk("t2_sbyte", m1_rdata, 32'hFFFFFF80);
        step; m1_req = 0;
        @(negedge clk);
        chk("t2_ubyte", m1_rdata, 32'h00000080);
        // conflict from reset: m0, m1, m0, m1
        step; rst = 1;
        step; rst = 0;
        set0(1, 0, 14'h010, 2'b10, 0, 0);
        set1(1, 0, 14'h013, 2'b00, 0, 0);
        @(negedge clk);
        chk("t3_c0", 32'({m0_gnt, m1_gnt}), 32'b10);
        step;
        @(negedge clk);
        chk("t3_c1", 32'({m0_gnt, m1_gnt}), 32'b01);
        chk("t3_d1", 32'({m0_done, m1_done}), 32'b10);
        step;
        @(negedge clk);
        chk("t3_c2", 32'({m0_gnt, m1_gnt}), 32'b10);
        chk("t3_d2", 32'({m0_done, m1_done}), 32'b01);
        step;
        @(negedge clk);
        chk("t3_c3", 32'({m0_gnt, m1_gnt}), 32'b01);
        step; m0_req = 0; m1_req = 0;
        // misaligned half load and word store
        step; set0(1, 0, 14'h005, 2'b01, 0, 0); set1(1, 1, 14'h006, 2'b10, 0, 32'h12345678);
        @(negedge clk);
        chk("t4_m0_gnt", 32'(m0_gnt), 1);
        chk("t4_ren", 32'(mem_ren), 0);
        step; m0_req = 0;
        @(negedge clk);
        chk("t4_m1_gnt", 32'(m1_gnt), 1);
        chk("t4_we", 32'(mem_we), 0);
        chk("t4_m0_err", 32'({m0_done, m0_err}), 32'b11);
        chk("t4_m0_rdata", m0_rdata, 0);
        step; m1_req = 0; set0(1, 0, 14'h004, 2'b10, 0, 0);
        @(negedge clk);
        chk("t4_m1_err", 32'({m1_done, m1_err}), 32'b11);
        step; m0_req = 0;
        @(negedge clk);
        chk("t4_unchanged", m0_rdata, 0);
        // half store 0xA55A at 0x00A
        step; set0(1, 1, 14'h00A, 2'b01, 0, 32'hA55A);
        @(negedge clk);
        chk("t5_be", 32'(mem_byte_en), 32'hC);
        step; set0(1, 0, 14'h00A, 2'b01, 1, 0);
        step; set0(1, 0, 14'h00A, 2'b01, 0, 0);
        @(negedge clk);
        chk("t5_uhalf", m0_rdata, 32'h0000A55A);
        step; m0_req = 0;
        @(negedge clk);
        chk("t5_shalf", m0_rdata, 32'hFFFFA55A);
        // reset right after a load grant
        step; set0(1, 0, 14'h010, 2'b10, 0, 0);
        @(negedge clk);
        chk("t6_gnt", 32'(m0_gnt), 1);
        step; rst = 1; m0_req = 0;
        @(negedge clk);
        chk("t6_no_done", 32'(m0_done), 0);
        step; m0_req = 1; set1(1, 0, 14'h013, 2'b00, 0, 0);
        @(negedge clk);
        chk("t6_gnt_in_rst", 32'({m0_gnt, m1_gnt}), 0);
        step; rst = 0;
        @(negedge clk);
        chk("t6_first_conflict", 32'({m0_gnt, m1_gnt}), 32'b10);
        step; m0_req = 0;
        step; m1_req = 0;
        // back-to-back mixed traffic on overlapping bytes
        step; k0 = 0; k1 = 0; op0(k0); op1(k1);
        repeat (16) begin
            @(negedge clk);
            g0 = m0_gnt;
            g1 = m1_gnt;
            step;
            if (g0) begin k0++; op0(k0); end
            if (g1) begin k1++; op1(k1); end
        end
        m0_req = 0; m1_req = 0;
        step; step; step;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/dmem_arb.md
# dmem_arb

Two-requester controller for the single-ported data memory. It sits between the pipeline MEM stage (master 0) and a secondary master (master 1: DMA/debug loader) on one side, and the `dmem` byte-enable RAM on the other. It arbitrates round-robin and translates byte-addressed byte/half/word accesses into word address, byte enables and replicated write data. It returns aligned, sign- or zero-extended load data one cycle after grant.

## Interface
- `ADDR_WIDTH`, 12, word-address width of the attached `dmem`; byte address is `ADDR_WIDTH+2` bits.
- `clk` in 1: clock; all state on rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `mX_req` in 1 (X=0,1): request valid; fields below held stable until `mX_gnt`.
- `mX_we` in 1: 1 = store, 0 = load.
- `mX_addr` in ADDR_WIDTH+2: byte address.
- `mX_size` in 2: 00 byte, 01 half, 10 word, 11 treated as word.
- `mX_unsigned` in 1: load zero-extends when 1, sign-extends when 0.
- `mX_wdata` in 32: store data, right-justified.
- `mX_gnt` out 1: request accepted this cycle (combinational).
- `mX_done` out 1: one-cycle response pulse for the accepted request.
- `mX_rdata` out 32: extended load data, valid with `mX_done` for loads; 0 otherwise.
- `mX_err` out 1: misaligned access, valid with `mX_done`.
- `mem_we`, `mem_byte_en[3:0]`, `mem_addr_w[ADDR_WIDTH-1:0]`, `mem_wdata[31:0]` out: dmem write port.
- `mem_ren`, `mem_addr_r[ADDR_WIDTH-1:0]` out: dmem read port.
- `mem_rdata` in 32: dmem registered read data.

## Operation
- Arbitration: at most one grant per cycle. With a single requester, it is granted. On a conflict, the master not granted last wins. The `last` register updates on every grant. Reset value of `last` is 1, so m0 wins the first conflict.
- Offset `off = addr[1:0]`. Word address is `addr[ADDR_WIDTH+1:2]`, driven on both `mem_addr_w` and `mem_addr_r`.
- Misaligned: half with `off[0]=1`, or word with `off!=0`. The request is granted, but `mem_we` and `mem_ren` stay 0. The response has `err=1` and `rdata=0`.
- Store, granted and aligned:
  - `mem_we=1`.
  - Byte enables: byte `4'b0001<<off`; half `4'b0011<<off`; word `4'b1111`.
  - `mem_wdata`: byte `{4{wdata[7:0]}}`; half `{2{wdata[15:0]}}`; word `wdata`.
- Load, granted and aligned: `mem_ren=1`, `mem_byte_en=0`.
- When nothing is granted, all `mem_*` outputs are 0.
- Response register, loaded on each grant: {valid, master id, we, size, unsigned, off, err}. It is cleared when no grant occurs.
- Response cycle: `done` and `err` are driven to the recorded master. For aligned loads, `rdata` is extracted combinationally from `mem_rdata >> (8*off)`:
  - byte: `[7:0]` extended to 32 bits.
  - half: `[15:0]` extended to 32 bits.
  - word: as is.
- Every grant produces exactly one `done`, exactly one cycle later. No other `done` pulses occur.

## Timing
- Grant at cycle N (edge N latches the store into dmem, or captures the dmem read). `done` is in cycle N+1. Load latency from grant is 1 cycle.
- Back-to-back grants every cycle are supported, to either master, in any load/store mix.
- Store then load to the same word in consecutive cycles returns the new data: the write lands at edge N, the read is captured at edge N+1.
- Losing master keeps `req` asserted. It is granted on the next cycle, because the round-robin pointer has moved.
- Reset values: `gnt`, `done`, `err`, `rdata`, and all `mem_*` outputs are 0; response valid is 0; `last`=1.
- While `rst` is high, `gnt` is forced to 0.
- Reset asserted mid-operation: the outstanding response is dropped (no `done` after reset). Any store already latched by dmem stays written.

## Test plan
- Single m0 word store to 0x010 (data 0xDEADBEEF), then load from 0x010 signed word -> `mem_byte_en=1111`, `mem_addr_w=4`, store `done` in the next cycle; load `done` one cycle after grant with `rdata=0xDEADBEEF`.
- m1 stores byte 0x80 to 0x013 -> `byte_en=1000`, `mem_wdata=0x80808080`. Follow-up loads of 0x013 as signed byte return 0xFFFFFF80, and as unsigned byte return 0x00000080.
- Both masters request continuously for 4 cycles, starting from reset -> grants go m0, m1, m0, m1. Each `done` appears one cycle after its own grant, only on the granted master.
- m0 half load at 0x005, and m1 word store at 0x006 -> both granted with `mem_we=mem_ren=0`, `done=1`, `err=1`, `rdata=0`; memory is unchanged.
- Half store 0xA55A to 0x00A, then unsigned half load of 0x00A -> `byte_en=1100`, load `rdata=0x0000A55A`. A signed half load of 0x00A returns 0xFFFFA55A.
- Assert `rst` in the cycle after a load grant -> no `done` pulse; all outputs are 0 while in reset. After reset is released, the first conflict is granted to m0.
